spmem_arbiter: RTL and testbench

Two-requester arbiter in front of the 256x16 single-port memory. Each cycle it grants at most one requester and drives the memory's address, din and wen ports. It returns read data to the requester that issued the read. Arbitration is round-robin, plus an optional bounded lock for atomic multi-access sequences such as read-modify-write.

---
 rtl/spmem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spmem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spmem_arbiter.sv
// spmem_arbiter: two-requester round-robin arbiter in front of a 256x16
// single-port memory, with a bounded lock for atomic multi-access sequences.

// Per-requester read return: one-cycle registered valid, data gated by valid.
module spmem_arb_rsp #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              gnt,
  input  logic              wen,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  // A granted read returns data the cycle after the grant.
  always_ff @(posedge clock or posedge reset)
    if (reset) rvalid <= 1'b0;
    else       rvalid <= gnt & ~wen;

  assign rdata = rvalid ? mem_dout : '0;
endmodule

module spmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_wen,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_wen,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        lock_owner
);
  localparam int NREQ = 2;
  localparam logic [8:0] MAXL9 = 9'(MAX_LOCK);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'b00,
    LOCK_A    = 2'b01,
    LOCK_B    = 2'b10
  } lock_e;

  // Index 0 is requester A, index 1 is requester B.
  logic [NREQ-1:0]             req, wen, lck, gnt, rvalid;
  logic [NREQ-1:0][ADDR_W-1:0] addr;
  logic [NREQ-1:0][DATA_W-1:0] din, rdata;

  assign req  = {b_req,  a_req};
  assign wen  = {b_wen,  a_wen};
  assign lck  = {b_lock, a_lock};
  assign addr = {b_addr, a_addr};
  assign din  = {b_din,  a_din};

  lock_e      state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       last, last_nxt;   // 0 = A was granted last, 1 = B
  logic       win;              // index of the granted requester
  logic       own;

  assign win = gnt[1];

  // Grant selection: a live lock wins outright, otherwise round-robin on last.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (state == LOCK_A && req[0])      gnt = 2'b01;
      else if (state == LOCK_B && req[1]) gnt = 2'b10;
      else if (&req)                      gnt = last ? 2'b01 : 2'b10;
      else                                gnt = req;
    end
  end

  // Memory port follows the winner; idle cycles drive zeros.
  always_comb begin
    mem_address = '0;
    mem_din     = '0;
    mem_wen     = 1'b0;
    if (|gnt) begin
      mem_address = addr[win];
      mem_din     = din[win];
      mem_wen     = wen[win];
    end
  end

  // Lock FSM next state. A lock ends on the owner's unlocked grant, on the
  // owner going idle, or on the MAX_LOCK-th grant (timeout). Since last is
  // the owner at that point, a waiting peer wins the following cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    own       = 1'b0;
    if (|gnt) last_nxt = win;
    case (state)
      LOCK_NONE: begin
        if ((|gnt) && lck[win] && (MAX_LOCK > 1)) begin
          state_nxt = win ? LOCK_B : LOCK_A;
          cnt_nxt   = 8'd1;
        end
      end
      LOCK_A, LOCK_B: begin
        own = (state == LOCK_B);
        if (!req[own] || !lck[own] || (({1'b0, cnt} + 9'd1) >= MAXL9)) begin
          state_nxt = LOCK_NONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = LOCK_NONE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Arbitration state; reset leaves last=B so A wins the first tie.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= LOCK_NONE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end

  assign lock_owner = state;

  for (genvar i = 0; i < NREQ; i++) begin : g_rsp
    spmem_arb_rsp #(.DATA_W(DATA_W)) u_rsp (
      .clock    (clock),
      .reset    (reset),
      .gnt      (gnt[i]),
      .wen      (wen[i]),
      .mem_dout (mem_dout),
      .rvalid   (rvalid[i]),
      .rdata    (rdata[i])
    );
  end

  assign a_gnt    = gnt[0];
  assign b_gnt    = gnt[1];
  assign a_rvalid = rvalid[0];
  assign b_rvalid = rvalid[1];
  assign a_rdata  = rdata[0];
  assign b_rdata  = rdata[1];
endmodule

// File: tb/tb_spmem_arbiter.sv
// tb_spmem_arbiter: directed scenarios plus random traffic, checked every
// cycle against a behavioural arbiter/memory model.
module tb_spmem_arbiter;
  localparam int AW = 8, DW = 16, MAXL = 4;

  logic          clock = 1'b0, reset;
  logic          a_req, a_wen, a_lock, a_gnt, a_rvalid;
  logic          b_req, b_wen, b_lock, b_gnt, b_rvalid;
  logic [AW-1:0] a_addr, b_addr, mem_address;
  logic [DW-1:0] a_din, b_din, a_rdata, b_rdata, mem_din, mem_dout;
  logic          mem_wen;
  logic [1:0]    lock_owner;

  always #5 clock = ~clock;

  spmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAXL)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_wen(a_wen), .a_lock(a_lock), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wen(b_wen), .b_lock(b_lock), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_din(mem_din), .mem_wen(mem_wen),
    .mem_dout(mem_dout), .lock_owner(lock_owner)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 257) ^ 16'h5a3c;
  endfunction

  // Bench memory: registered read, contents reloaded while reset is high.
  logic [DW-1:0] mem [0:255];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_dout <= '0;
    end else begin
      if (mem_wen) mem[mem_address] <= mem_din;
      mem_dout <= mem[mem_address];
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0 none / 1 A / 2 B, last 1 A / 2 B, pending read
  // data per requester (-1 when nothing returns next cycle).
  logic [DW-1:0] ref_mem [0:255];
  int m_own, m_cnt, m_last, pend_a, pend_b, last_g, run_a;

  task automatic cyc();
    int g;
    logic own_req, own_lck;
    @(negedge clock);
    if (reset) begin
      chk("rst_gnt", {a_gnt, b_gnt}, 0);
      chk("rst_wen", mem_wen, 0);
      chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
      chk("rst_owner", lock_owner, 0);
      m_own = 0; m_cnt = 0; m_last = 2; pend_a = -1; pend_b = -1; run_a = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      g = 0;
    end else begin
      if (m_own == 1 && a_req)      g = 1;
      else if (m_own == 2 && b_req) g = 2;
      else if (a_req && b_req)      g = (m_last == 1) ? 2 : 1;
      else if (a_req)               g = 1;
      else if (b_req)               g = 2;
      else                          g = 0;
      chk("a_gnt", a_gnt, g == 1);
      chk("b_gnt", b_gnt, g == 2);
      chk("mem_address", mem_address, g == 1 ? a_addr : g == 2 ? b_addr : 0);
      chk("mem_din", mem_din, g == 1 ? a_din : g == 2 ? b_din : 0);
      chk("mem_wen", mem_wen, g == 1 ? a_wen : g == 2 ? b_wen : 0);
      chk("a_rvalid", a_rvalid, pend_a >= 0);
      chk("a_rdata", a_rdata, pend_a >= 0 ? pend_a : 0);
      chk("b_rvalid", b_rvalid, pend_b >= 0);
      chk("b_rdata", b_rdata, pend_b >= 0 ? pend_b : 0);
      chk("lock_owner", lock_owner, m_own);
      // With B waiting, A may never hold more than MAX_LOCK grants in a row.
      if (a_gnt && b_req) run_a++; else run_a = 0;
      chk("a_run", run_a <= MAXL, 1);
      // advance the model across the coming edge
      pend_a = (g == 1 && !a_wen) ? int'(ref_mem[a_addr]) : -1;
      pend_b = (g == 2 && !b_wen) ? int'(ref_mem[b_addr]) : -1;
      if (g == 1 && a_wen) ref_mem[a_addr] = a_din;
      if (g == 2 && b_wen) ref_mem[b_addr] = b_din;
      if (m_own != 0) begin
        own_req = (m_own == 1) ? a_req  : b_req;
        own_lck = (m_own == 1) ? a_lock : b_lock;
        if (own_req && own_lck && m_cnt + 1 < MAXL) m_cnt++;
        else begin m_own = 0; m_cnt = 0; end
      end else if (g != 0 && ((g == 1) ? a_lock : b_lock) && MAXL > 1) begin
        m_own = g; m_cnt = 1;
      end
      if (g != 0) m_last = g;
    end
    last_g = g;
    @(posedge clock); #1;
  endtask

  // Random requester: hold a pending command, sometimes withdraw it.
  task automatic drive_rand();
    if (a_req && last_g != 1) begin
      if ($urandom_range(7) == 0) a_req = 1'b0;
    end else begin
      a_req = $urandom_range(3) != 0; a_wen = 1'($urandom); a_lock = $urandom_range(2) != 0;
      a_addr = AW'($urandom_range(15)); a_din = DW'($urandom);
    end
    if (b_req && last_g != 2) begin
      if ($urandom_range(7) == 0) b_req = 1'b0;
    end else begin
      b_req = $urandom_range(3) != 0; b_wen = 1'($urandom); b_lock = $urandom_range(2) != 0;
      b_addr = AW'($urandom_range(15)); b_din = DW'($urandom);
    end
  endtask

  task automatic idle();
    a_req = 0; b_req = 0; a_lock = 0; b_lock = 0;
    cyc();
  endtask

  initial begin
    int li;
    last_g = 0;
    a_wen = 0; a_lock = 0; a_addr = 8'h10; a_din = 0;
    b_wen = 0; b_lock = 0; b_addr = 8'h20; b_din = 0;
    // reset held with both requesting: no grants may leak out
    reset = 1; a_req = 1; b_req = 1;
    cyc(); cyc();
    reset = 0;

    // both read and hold: A first, then strict alternation
    for (int k = 0; k < 6; k++) cyc();
    idle();

    // write 0xBEEF to 0x05, read it back on the next cycle
    a_req = 1; a_wen = 1; a_addr = 8'h05; a_din = 16'hBEEF;
    cyc();
    a_wen = 0;
    cyc();
    a_req = 0;
    chk("beef_rvalid", a_rvalid, 1);
    chk("beef_rdata", a_rdata, 16'hBEEF);
    cyc();
    idle();

    // A locked sequence (lock 1,1,0) against a continuously requesting B
    li = 0;
    a_req = 1; a_wen = 0; a_lock = 1; a_addr = 8'h30;
    b_req = 1; b_wen = 0; b_lock = 0; b_addr = 8'h31;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (last_g == 1 && a_req) begin
        li++;
        if (li == 3) a_req = 0;
        else begin a_lock = (li < 2); a_addr = AW'(8'h30 + li); end
      end
    end
    idle();

    // lock timeout: A keeps locking for 10 cycles while B waits
    a_req = 1; a_lock = 1; a_wen = 0; a_addr = 8'h40;
    b_req = 1; b_lock = 0; b_wen = 1; b_addr = 8'h41; b_din = 16'h1234;
    for (int k = 0; k < 10; k++) cyc();
    idle();

    // A drops its request inside LOCK_A while B requests
    a_req = 1; a_lock = 1; a_wen = 0; a_addr = 8'h50; b_req = 0;
    cyc();
    a_req = 0; b_req = 1; b_wen = 0; b_addr = 8'h51;
    cyc();
    b_req = 0;
    cyc();
    idle();

    // read granted, then reset arrives mid-way through the return cycle
    a_req = 1; a_wen = 0; a_lock = 1; a_addr = 8'h07; b_req = 0;
    cyc();
    a_req = 0;
    #2 reset = 1;
    cyc();
    a_req = 1; a_lock = 0; a_addr = 8'h08; b_req = 1; b_wen = 0; b_addr = 8'h09;
    reset = 0;
    #1 chk("post_rst_tie", {a_gnt, b_gnt}, 2'b10);
    cyc(); cyc();
    idle();

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      drive_rand();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
